pdua_control_unit: RTL and testbench
====================================

# pdua_control_unit

Hardwired multi-cycle control FSM for the PDUA 8-bit processor. It sits upstream of the ALU and drives its `selop`, `shamt` and `enaf` inputs. It consumes the registered C/N/P/Z flags the ALU produces to resolve conditional jumps. It also sequences instruction fetch, operand fetch, memory access and accumulator write-back over a ready-handshaked memory port.

## Interface
- `MAX_WIDTH`, 8, datapath/instruction width; fixed at 8 for the encoding below.
- `clk`  in  1  system clock, all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_rdata`  in  MAX_WIDTH  memory read data (instruction or operand byte).
- `mem_ready`  in  1  memory completes the current `mem_rd`/`mem_wr` this cycle.
- `C`, `N`, `P`, `Z`  in  1 each  registered ALU flags.
- `selop`  out  3  ALU operation select.
- `shamt`  out  2  ALU shift select.
- `enaf`  out  1  ALU flag-register update enable.
- `acc_we`  out  1  accumulator write enable.
- `acc_src`  out  1  accumulator source: 0 = ALU `busC`, 1 = `mem_rdata`.
- `ir_we`, `opr_we`  out  1 each  instruction / operand register load.
- `pc_inc`, `pc_load`  out  1 each  PC increment / load from operand register.
- `addr_sel`  out  1  memory address: 0 = PC, 1 = operand register.
- `mem_rd`, `mem_wr`  out  1 each  memory request strobes.
- `halted`, `illegal`  out  1 each  sticky status.

## Operation
- Instruction byte: `ir[7:5]` class, `ir[4:3]` shamt, `ir[2:0]` selop or condition.
- Classes:
  - 000 ALU: `selop=ir[2:0]`, `shamt=ir[4:3]`, `enaf=1`, `acc_we=1`, `acc_src=0`.
  - 001 LDI: next byte → ACC.
  - 010 LDM: next byte is address; mem[addr] → ACC.
  - 011 STM: next byte is address; ACC → mem[addr].
  - 100 JMP: next byte is target; jump if condition true.
  - 111 HALT.
  - 101/110: illegal; set `illegal`, enter HALT.
- Conditions `ir[2:0]`:
  - 000 always, 001 Z, 010 N, 011 C, 100 P.
  - 101 !Z, 110 !N, 111 !C.
- FSM states: FETCH, DECODE, FETCH_OP, EXEC, MEM, HALT.
- Transitions:
  - FETCH: `mem_rd=1`, `addr_sel=0`. On `mem_ready`: `ir_we=1`, `pc_inc=1` → DECODE.
  - DECODE: ALU class → EXEC. HALT → HALT. Illegal → HALT with `illegal`. Others → FETCH_OP.
  - FETCH_OP: `mem_rd=1`, `addr_sel=0`. On `mem_ready`: `opr_we=1`, `pc_inc=1`. LDI also sets `acc_we=1`, `acc_src=1` and → FETCH; other classes → EXEC.
  - EXEC:
    - ALU: strobes for one cycle → FETCH.
    - JMP: `pc_load` = condition true → FETCH.
    - LDM/STM → MEM.
  - MEM: `addr_sel=1`, `mem_rd` (LDM) or `mem_wr` (STM) held. On `mem_ready`: LDM also sets `acc_we=1`, `acc_src=1` → FETCH.
  - HALT: absorbing; all strobes 0, `halted=1`. Only `rst` exits.
- Outside the active states above, `selop`, `shamt`, `enaf` and `acc_we` are 0.
- Only ALU-class instructions set `enaf`; loads, stores and jumps leave the flags unchanged.

## Timing
- Outputs are Moore-style from state and IR. Exceptions: `ir_we`, `opr_we`, `pc_inc` and memory-path `acc_we` are qualified by `mem_ready` in the same cycle.
- Reset: state = FETCH; `halted=0`, `illegal=0`. During the `rst` cycle all outputs are 0. The first `mem_rd` is in the cycle after `rst` deasserts.
- `mem_rd`/`mem_wr` stay asserted with a stable `addr_sel` until `mem_ready`. With `mem_ready` tied high, each wait costs 0 extra cycles.
- Cycles per instruction at zero wait: ALU 3, LDI 3, JMP 4, LDM/STM 5, plus one per wait cycle.
- The JMP condition is sampled in EXEC. Flags from an immediately preceding ALU instruction are already registered by then.
- `rst` mid-instruction aborts it: no `acc_we`, `mem_wr` or `pc_load` in the `rst` cycle.
- `mem_ready` asserted outside a request is ignored.

## Structure
- `pdua_pkg` holds:
  - class codes and condition codes;
  - the state enum;
  - field positions.
- One sub-module: `branch_cond`, combinational: flags + `ir[2:0]` → `take`.

## Test plan
- Reset: hold `rst` 2 cycles → all outputs 0. Next cycle `mem_rd=1`, `addr_sel=0`.
- ALU op: `mem_rdata=8'b000_01_011`, `mem_ready=1` → EXEC cycle has `selop=3'b011`, `shamt=2'b01`, `enaf=1`, `acc_we=1`. Back to FETCH after 3 cycles.
- Wait states on LDM: `8'h40`, `8'h80`, `mem_ready` low 2 cycles in MEM → `mem_rd`, `addr_sel=1` held 3 cycles. `acc_we`/`acc_src=1` only in the ready cycle.
- Conditional jump with Z=1 on `8'h81` / `8'h85` → `pc_load=1` for `8'h81`, `pc_load=0` for `8'h85`, in EXEC.
- Illegal `8'hA0` → `illegal=1` and `halted=1` from the cycle after DECODE. No strobes until `rst`, which clears both.
- `rst` asserted while in MEM for STM → no `mem_wr` in that cycle. FSM is in FETCH afterwards.

Source files
------------

// File: rtl/pdua_pkg.sv
// Shared encodings for the PDUA control unit: instruction fields, class and
// condition codes, and the control FSM state set.
package pdua_pkg;

    localparam int IR_CLASS_HI = 7;
    localparam int IR_CLASS_LO = 5;
    localparam int IR_SHAMT_HI = 4;
    localparam int IR_SHAMT_LO = 3;
    localparam int IR_FUNC_HI  = 2;
    localparam int IR_FUNC_LO  = 0;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'b000,
        CLS_LDI  = 3'b001,
        CLS_LDM  = 3'b010,
        CLS_STM  = 3'b011,
        CLS_JMP  = 3'b100,
        CLS_ILL5 = 3'b101,
        CLS_ILL6 = 3'b110,
        CLS_HALT = 3'b111
    } class_e;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_Z      = 3'b001,
        COND_N      = 3'b010,
        COND_C      = 3'b011,
        COND_P      = 3'b100,
        COND_NZ     = 3'b101,
        COND_NN     = 3'b110,
        COND_NC     = 3'b111
    } cond_e;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_FETCH_OP = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MEM      = 3'd4,
        ST_HALT     = 3'd5
    } state_e;

endpackage

// File: rtl/pdua_control_unit_branch_cond.sv
// Jump condition evaluator: maps the condition field and ALU flags to take.
module branch_cond
    import pdua_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic       c_i,
    input  logic       n_i,
    input  logic       p_i,
    input  logic       z_i,
    output logic       take_o
);

    always_comb begin
        take_o = 1'b0;
        case (cond_e'(cond_i))
            COND_ALWAYS: take_o = 1'b1;
            COND_Z:      take_o = z_i;
            COND_N:      take_o = n_i;
            COND_C:      take_o = c_i;
            COND_P:      take_o = p_i;
            COND_NZ:     take_o = ~z_i;
            COND_NN:     take_o = ~n_i;
            COND_NC:     take_o = ~c_i;
            default:     take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pdua_control_unit.sv
// Hardwired multi-cycle control FSM for the PDUA 8-bit processor: sequences
// fetch, operand fetch, execute and memory access, and drives the ALU controls.
module pdua_control_unit
    import pdua_pkg::*;
#(
    parameter int MAX_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAX_WIDTH-1:0] mem_rdata,
    input  logic                 mem_ready,
    input  logic                 C,
    input  logic                 N,
    input  logic                 P,
    input  logic                 Z,
    output logic [2:0]           selop,
    output logic [1:0]           shamt,
    output logic                 enaf,
    output logic                 acc_we,
    output logic                 acc_src,
    output logic                 ir_we,
    output logic                 opr_we,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic                 addr_sel,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 halted,
    output logic                 illegal
);

    state_e               state_q, state_d;
    logic [MAX_WIDTH-1:0] ir_q, ir_d;
    logic                 illegal_q, illegal_d;
    logic                 take;
    class_e               cls;

    assign cls = class_e'(ir_q[IR_CLASS_HI:IR_CLASS_LO]);

    branch_cond u_branch_cond (
        .cond_i (ir_q[IR_FUNC_HI:IR_FUNC_LO]),
        .c_i    (C),
        .n_i    (N),
        .p_i    (P),
        .z_i    (Z),
        .take_o (take)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        selop     = 3'b000;
        shamt     = 2'b00;
        enaf      = 1'b0;
        acc_we    = 1'b0;
        acc_src   = 1'b0;
        ir_we     = 1'b0;
        opr_we    = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        addr_sel  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        halted    = 1'b0;
        illegal   = illegal_q;

        case (state_q)
            ST_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_inc  = 1'b1;
                    ir_d    = mem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (cls)
                    CLS_ALU:  state_d = ST_EXEC;
                    CLS_HALT: state_d = ST_HALT;
                    CLS_ILL5, CLS_ILL6: begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                    default:  state_d = ST_FETCH_OP;
                endcase
            end
            ST_FETCH_OP: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    opr_we = 1'b1;
                    pc_inc = 1'b1;
                    if (cls == CLS_LDI) begin
                        acc_we  = 1'b1;
                        acc_src = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                case (cls)
                    CLS_ALU: begin
                        selop   = ir_q[IR_FUNC_HI:IR_FUNC_LO];
                        shamt   = ir_q[IR_SHAMT_HI:IR_SHAMT_LO];
                        enaf    = 1'b1;
                        acc_we  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_JMP: begin
                        pc_load = take;
                        state_d = ST_FETCH;
                    end
                    CLS_LDM, CLS_STM: state_d = ST_MEM;
                    default:          state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                // Address and strobe are held steady until the memory accepts.
                addr_sel = 1'b1;
                mem_rd   = (cls == CLS_LDM);
                mem_wr   = (cls == CLS_STM);
                if (mem_ready) begin
                    if (cls == CLS_LDM) begin
                        acc_we  = 1'b1;
                        acc_src = 1'b1;
                    end
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset aborts whatever is in flight: nothing may leak out this cycle.
        if (rst) begin
            selop    = 3'b000;
            shamt    = 2'b00;
            enaf     = 1'b0;
            acc_we   = 1'b0;
            acc_src  = 1'b0;
            ir_we    = 1'b0;
            opr_we   = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
            addr_sel = 1'b0;
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            halted   = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_pdua_control_unit.sv
// Scoreboard bench for pdua_control_unit: an instruction-level schedule model
// pushes the expected per-cycle control word, a monitor compares at negedge.
module tb_pdua_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ready = 1'b0;
    logic       C = 1'b0, N = 1'b0, P = 1'b0, Z = 1'b0;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic enaf, acc_we, acc_src, ir_we, opr_we, pc_inc, pc_load;
    logic addr_sel, mem_rd, mem_wr, halted, illegal;

    pdua_control_unit #(.MAX_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .C(C), .N(N), .P(P), .Z(Z),
        .selop(selop), .shamt(shamt), .enaf(enaf), .acc_we(acc_we),
        .acc_src(acc_src), .ir_we(ir_we), .opr_we(opr_we), .pc_inc(pc_inc),
        .pc_load(pc_load), .addr_sel(addr_sel), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Control word bit positions (bit 0 spare, always 0).
    localparam logic [17:0] W_ENAF    = 18'h1 << 12;
    localparam logic [17:0] W_ACCWE   = 18'h1 << 11;
    localparam logic [17:0] W_ACCSRC  = 18'h1 << 10;
    localparam logic [17:0] W_IRWE    = 18'h1 << 9;
    localparam logic [17:0] W_OPRWE   = 18'h1 << 8;
    localparam logic [17:0] W_PCINC   = 18'h1 << 7;
    localparam logic [17:0] W_PCLOAD  = 18'h1 << 6;
    localparam logic [17:0] W_ADDRSEL = 18'h1 << 5;
    localparam logic [17:0] W_MEMRD   = 18'h1 << 4;
    localparam logic [17:0] W_MEMWR   = 18'h1 << 3;
    localparam logic [17:0] W_HALTED  = 18'h1 << 2;
    localparam logic [17:0] W_ILLEGAL = 18'h1 << 1;

    typedef struct {
        logic [17:0] v;
        string       tag;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] flags_next = 4'b0000;   // {C,N,P,Z}

    wire [17:0] act = {selop, shamt, enaf, acc_we, acc_src, ir_we, opr_we,
                       pc_inc, pc_load, addr_sel, mem_rd, mem_wr, halted,
                       illegal, 1'b0};

    initial begin : monitor
        exp_t it;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                checks++;
                if (act !== it.v) begin
                    errors++;
                    $display("FAIL %s: got=%05h exp=%05h", it.tag, act, it.v);
                end
            end
        end
    end

    function automatic bit cond_true(input logic [2:0] c, input logic [3:0] f);
        case (c)
            3'd0: return 1'b1;
            3'd1: return f[0];
            3'd2: return f[2];
            3'd3: return f[3];
            3'd4: return f[1];
            3'd5: return !f[0];
            3'd6: return !f[2];
            default: return !f[3];
        endcase
    endfunction

    task automatic cyc(input logic r, input logic rdy, input logic [7:0] rd,
                       input logic [17:0] e, input string tag);
        exp_t it;
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        mem_rdata = rd;
        {C, N, P, Z} = flags_next;
        it.v   = e;
        it.tag = tag;
        exp_q.push_back(it);
    endtask

    // Non-request cycle: mem_ready is noise and must be ignored.
    task automatic idle(input logic [17:0] e, input string tag);
        cyc(1'b0, 1'($urandom_range(1)), 8'($urandom), e, tag);
    endtask

    task automatic req(input logic [17:0] base, input int waits, input logic [7:0] b,
                       input logic [17:0] on_ready, input string tag);
        for (int i = 0; i < waits; i++) cyc(1'b0, 1'b0, 8'($urandom), base, tag);
        cyc(1'b0, 1'b1, b, base | on_ready, tag);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom_range(1)), 8'($urandom), 18'h0, "reset");
    endtask

    task automatic run_instr(input logic [7:0] opc, input logic [7:0] opd,
                             input int w0, input int w1, input int w2,
                             input bit abort_in_mem);
        logic [2:0] cls = opc[7:5];
        logic [17:0] e;
        $display("instr op=%02h opd=%02h flags=%b waits=%0d/%0d/%0d abort=%0d",
                 opc, opd, flags_next, w0, w1, w2, abort_in_mem);
        req(W_MEMRD, w0, opc, W_IRWE | W_PCINC, "fetch");
        idle(18'h0, "decode");
        case (cls)
            3'b000: begin
                e = {opc[2:0], opc[4:3], 13'h0} | W_ENAF | W_ACCWE;
                idle(e, "exec_alu");
            end
            3'b001: req(W_MEMRD, w1, opd, W_OPRWE | W_PCINC | W_ACCWE | W_ACCSRC, "ldi_op");
            3'b100: begin
                req(W_MEMRD, w1, opd, W_OPRWE | W_PCINC, "jmp_op");
                idle(cond_true(opc[2:0], flags_next) ? W_PCLOAD : 18'h0, "exec_jmp");
            end
            3'b010, 3'b011: begin
                req(W_MEMRD, w1, opd, W_OPRWE | W_PCINC, "mem_op");
                idle(18'h0, "exec_mem");
                e = W_ADDRSEL | ((cls == 3'b010) ? W_MEMRD : W_MEMWR);
                if (abort_in_mem) begin
                    cyc(1'b0, 1'b0, 8'($urandom), e, "mem_wait");
                    do_reset(1);
                    cyc(1'b0, 1'b0, 8'($urandom), W_MEMRD, "fetch_after_abort");
                    cyc(1'b0, 1'b1, 8'h00, W_MEMRD | W_IRWE | W_PCINC, "fetch_after_abort");
                    idle(18'h0, "decode");
                    idle(W_ENAF | W_ACCWE, "exec_alu");
                end else begin
                    req(e, w2, 8'($urandom),
                        (cls == 3'b010) ? (W_ACCWE | W_ACCSRC) : 18'h0, "mem");
                end
            end
            default: begin
                e = W_HALTED | ((cls == 3'b111) ? 18'h0 : W_ILLEGAL);
                for (int i = 0; i < 4; i++) idle(e, "halt");
            end
        endcase
    endtask

    initial begin : stim
        logic [2:0] legal [5];
        logic [7:0] opc;
        legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
        legal[3] = 3'b011; legal[4] = 3'b100;

        repeat (2) @(posedge clk);
        do_reset(2);
        run_instr(8'b000_01_011, 8'h00, 0, 0, 0, 1'b0);
        run_instr(8'h40, 8'h80, 0, 0, 2, 1'b0);
        flags_next = 4'b0001;
        run_instr(8'h81, 8'h10, 0, 0, 0, 1'b0);
        run_instr(8'h85, 8'h20, 0, 0, 0, 1'b0);

        for (int k = 0; k < 80; k++) begin
            flags_next = 4'($urandom);
            opc = 8'($urandom);
            opc[7:5] = legal[$urandom_range(4)];
            run_instr(opc, 8'($urandom), $urandom_range(2), $urandom_range(2),
                      $urandom_range(2), 1'b0);
        end

        run_instr(8'h60, 8'h33, 0, 0, 0, 1'b1);
        run_instr(8'hA0, 8'h00, 0, 0, 0, 1'b0);
        do_reset(1);
        run_instr(8'h01, 8'h00, 1, 0, 0, 1'b0);
        run_instr(8'hC7, 8'h00, 0, 0, 0, 1'b0);
        do_reset(1);
        run_instr(8'hE0, 8'h00, 0, 0, 0, 1'b0);
        do_reset(1);
        run_instr(8'h22, 8'h5A, 2, 1, 0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got=%0d pending exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
